morse_symbol_decoder: RTL

Receive-side front end for the Morse board: turns a single active-low telegraph key into alphabet codes. It times each press and gap in unit ticks, classifies presses as dot or dash, and assembles letters. Each completed letter is shifted into a 4-character display word. That word drives the `seg7alp` digit chain through the top-level `Menu` mux, in place of the RX count.

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_lut.sv | 45 ++++
 rtl/morse_symbol_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive front end: seg7alp alphabet
// codes, the decoder FSM state type and the all-blank display word.
package morse_pkg;

    localparam logic [4:0]  CODE_A     = 5'd0;
    localparam logic [4:0]  CODE_ERR   = 5'd30;
    localparam logic [4:0]  CODE_BLANK = 5'd31;
    localparam logic [19:0] WORD_BLANK = {4{CODE_BLANK}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse pattern lookup. Pattern holds the first symbol in
// bit 3 (1 = dash); bits below the current length are ignored.
module morse_lut
    import morse_pkg::*;
(
    input  logic [3:0] pattern_i,
    input  logic [2:0] len_i,
    output logic [4:0] code_o
);

    // Map {length, pattern} to an alphabet code, ERR for anything unlisted.
    always_comb begin
        code_o = CODE_ERR;
        casez ({len_i, pattern_i})
            7'b001_0???: code_o = CODE_A + 5'd4;   // E
            7'b001_1???: code_o = CODE_A + 5'd19;  // T
            7'b010_00??: code_o = CODE_A + 5'd8;   // I
            7'b010_01??: code_o = CODE_A + 5'd0;   // A
            7'b010_10??: code_o = CODE_A + 5'd13;  // N
            7'b010_11??: code_o = CODE_A + 5'd12;  // M
            7'b011_000?: code_o = CODE_A + 5'd18;  // S
            7'b011_001?: code_o = CODE_A + 5'd20;  // U
            7'b011_010?: code_o = CODE_A + 5'd17;  // R
            7'b011_011?: code_o = CODE_A + 5'd22;  // W
            7'b011_100?: code_o = CODE_A + 5'd3;   // D
            7'b011_101?: code_o = CODE_A + 5'd10;  // K
            7'b011_110?: code_o = CODE_A + 5'd6;   // G
            7'b011_111?: code_o = CODE_A + 5'd14;  // O
            7'b100_0000: code_o = CODE_A + 5'd7;   // H
            7'b100_0001: code_o = CODE_A + 5'd21;  // V
            7'b100_0010: code_o = CODE_A + 5'd5;   // F
            7'b100_0100: code_o = CODE_A + 5'd11;  // L
            7'b100_0110: code_o = CODE_A + 5'd15;  // P
            7'b100_0111: code_o = CODE_A + 5'd9;   // J
            7'b100_1000: code_o = CODE_A + 5'd1;   // B
            7'b100_1001: code_o = CODE_A + 5'd23;  // X
            7'b100_1010: code_o = CODE_A + 5'd2;   // C
            7'b100_1011: code_o = CODE_A + 5'd24;  // Y
            7'b100_1100: code_o = CODE_A + 5'd25;  // Z
            7'b100_1101: code_o = CODE_A + 5'd16;  // Q
            default:     code_o = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/morse_symbol_decoder.sv
// Telegraph key to alphabet decoder. Times presses and gaps in units of
// TICK_DIV cycles, classifies dot/dash, commits letters into a 4-character
// display word. Optional key debouncer is compiled in with MORSE_DEBOUNCE_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no letter in progress, waiting for a press
//   ST_PRESS  | key down, timing the press
//   ST_GAP    | key up with symbols pending, timing the gap
//   ST_COMMIT | one cycle: look up pattern, shift code into display word
module morse_symbol_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = 50_000,
    parameter int DASH_MIN   = 3,
    parameter int LETTER_GAP = 3,
    parameter int DEB_CYCLES = 250_000
) (
    input  logic        iCLK,
    input  logic        rst,
    input  logic        wKEY,
    input  logic        en,
    input  logic        clr,
    output logic [19:0] wcount,
    output logic [4:0]  letter,
    output logic        letter_valid,
    output logic [2:0]  sym_count,
    output logic        key_led
);

    localparam int             TW     = $clog2(TICK_DIV);
    localparam logic [TW-1:0]  TMAX   = TW'(TICK_DIV - 1);
    localparam logic [7:0]     DASH_U = 8'(DASH_MIN);
    localparam logic [7:0]     LG_U   = 8'(LETTER_GAP);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if (LETTER_GAP < 1) begin : g_bad_letter_gap
        $error("LETTER_GAP must be at least 1");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("DEB_CYCLES must be at least 1");
    end

    logic          sync1_q, sync2_q;
    logic          kd, kd_q, kd_edge, tick, commit;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    run_q, run_d;
    logic [3:0]    pat_q, pat_d;
    logic [2:0]    sym_q, sym_d;
    logic          ovf_q, ovf_d;
    state_e        state_q, state_d;
    logic [19:0]   wcount_q, wcount_d;
    logic [4:0]    letter_q, letter_d;
    logic          valid_q;
    logic [4:0]    lut_code, commit_code;

    // Two-flop synchronizer; reset to "released" so key_led starts low.
    always_ff @(posedge iCLK) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= wKEY;
            sync2_q <= sync1_q;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int            DW   = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DTOP = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_q;
    logic          key_stable_q;

    // Down-counter reloads while the level agrees; accepts a new level
    // only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge iCLK) begin
        if (!rst) begin
            deb_q        <= DTOP;
            key_stable_q <= 1'b1;
        end else if (sync2_q == key_stable_q) begin
            deb_q <= DTOP;
        end else if (deb_q == '0) begin
            deb_q        <= DTOP;
            key_stable_q <= sync2_q;
        end else begin
            deb_q <= deb_q - 1'b1;
        end
    end

    assign kd = ~key_stable_q;
`else
    assign kd = ~sync2_q;
`endif

    assign kd_edge = kd ^ kd_q;
    assign tick    = en && !kd_edge && (tmr_q == TMAX);
    assign tmr_d   = (!en || kd_edge || tmr_q == TMAX) ? '0 : tmr_q + 1'b1;

    morse_lut u_lut (
        .pattern_i (pat_q),
        .len_i     (sym_q),
        .code_o    (lut_code)
    );

    assign commit_code = ovf_q ? CODE_ERR : lut_code;

    // Next-state logic for the FSM and its symbol/run counters.
    always_comb begin
        state_d = state_q;
        run_d   = (tick && run_q != 8'hFF) ? run_q + 8'd1 : run_q;
        pat_d   = pat_q;
        sym_d   = sym_q;
        ovf_d   = ovf_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (kd) begin
                    state_d = ST_PRESS;
                    run_d   = '0;
                end
            end
            ST_PRESS: begin
                if (!kd) begin
                    run_d = '0;
                    if (run_q == 8'd0) begin
                        state_d = (sym_q == 3'd0) ? ST_IDLE : ST_GAP;
                    end else begin
                        state_d = ST_GAP;
                        if (sym_q < 3'd4) begin
                            if (run_q >= DASH_U) pat_d = pat_q | (4'b1000 >> sym_q);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (sym_q != 3'd7) sym_d = sym_q + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (kd) begin
                    state_d = ST_PRESS;
                    run_d   = '0;
                end else if (run_d >= LG_U) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                pat_d   = '0;
                sym_d   = '0;
                ovf_d   = 1'b0;
                run_d   = '0;
                state_d = kd ? ST_PRESS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!en) begin
            state_d = ST_IDLE;
            run_d   = '0;
            pat_d   = '0;
            sym_d   = '0;
            ovf_d   = 1'b0;
            commit  = 1'b0;
        end
    end

    // Display word and last-letter update; clear beats a same-cycle commit.
    always_comb begin
        wcount_d = wcount_q;
        letter_d = letter_q;
        if (commit) begin
            wcount_d = {wcount_q[14:0], commit_code};
            letter_d = commit_code;
        end
        if (clr) wcount_d = WORD_BLANK;
    end

    // State and datapath registers.
    always_ff @(posedge iCLK) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            kd_q     <= 1'b0;
            tmr_q    <= '0;
            run_q    <= '0;
            pat_q    <= '0;
            sym_q    <= '0;
            ovf_q    <= 1'b0;
            wcount_q <= WORD_BLANK;
            letter_q <= CODE_BLANK;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            kd_q     <= kd;
            tmr_q    <= tmr_d;
            run_q    <= run_d;
            pat_q    <= pat_d;
            sym_q    <= sym_d;
            ovf_q    <= ovf_d;
            wcount_q <= wcount_d;
            letter_q <= letter_d;
            valid_q  <= commit;
        end
    end

    assign wcount       = wcount_q;
    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign sym_count    = sym_q;
    assign key_led      = kd;

endmodule
